// File: rtl/coin_acceptor.sv
// Coin acceptor front end.
// Two raw coin sensors (5c and 10c) are synchronized and debounced. Every
// debounced rising level is a coin event. A lone event with enable high is
// queued in a small FIFO, and the FIFO drains one coin code per clock to the
// vending FSM. Disabled events, overflow events and simultaneous events on
// both channels are rejected with a one-cycle pulse.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       enable,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic [2:0] pending,
  output logic [7:0] coin_count
);

  // Codes handed to the vending FSM; 2'b11 is never produced.
  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10
  } coin_t;

  // Channel index 0 is the nickel sensor, index 1 is the dime sensor.
  localparam int CH_NICKEL = 0;
  localparam int CH_DIME   = 1;

  // Terminal value of the debounce counter: reaching it flips the level.
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // The pointers are two bits wide because the queue depth is fixed at four.
  localparam logic [2:0] FIFO_FULL_COUNT = 3'(FIFO_DEPTH);

  // Synchronizer, debounce and level state for both channels.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_deb;
  logic [1:0][3:0] r_debCnt;

  // Per-channel decode of the debounce state.
  logic [1:0] w_mismatch;
  logic [1:0] w_toggle;
  logic [1:0] w_event;

  // Queue storage, pointers and occupancy.
  coin_t      r_fifo [FIFO_DEPTH];
  logic [1:0] r_wrPtr;
  logic [1:0] r_rdPtr;
  logic [2:0] r_count;

  // Queue control decode.
  logic  w_pop;
  logic  w_full;
  logic  w_jam;
  logic  w_single;
  logic  w_push;
  logic  w_rejectNext;
  coin_t w_pushCode;

  // Registered outputs.
  coin_t      r_coin;
  logic       r_reject;
  logic       r_jam;
  logic [7:0] r_coinCount;

  assign w_raw = {dime_raw, nickel_raw};

  // Two-flop synchronizer per sensor; nothing downstream sees the raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level flips once the synchronized input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive samples; only a 0->1 flip is a coin event.
  always_comb begin
    w_mismatch = 2'b00;
    w_toggle   = 2'b00;
    w_event    = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      w_mismatch[ch] = r_sync2[ch] != r_deb[ch];
      w_toggle[ch]   = w_mismatch[ch] && (r_debCnt[ch] == DEB_LAST);
      w_event[ch]    = w_toggle[ch] && !r_deb[ch];
    end
  end

  // Debounce counters: count disagreement, clear on agreement or on a flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb    <= 2'b00;
      r_debCnt <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_toggle[ch]) begin
          r_deb[ch]    <= ~r_deb[ch];
          r_debCnt[ch] <= 4'd0;
        end else if (w_mismatch[ch]) begin
          r_debCnt[ch] <= r_debCnt[ch] + 4'd1;
        end else begin
          r_debCnt[ch] <= 4'd0;
        end
      end
    end
  end

  // A non-empty queue always drains one entry per clock. Because the pop is
  // decided from the occupancy before this edge, an entry written now cannot
  // leave on the same edge. A full queue that is also popping can take a push.
  always_comb begin
    w_pop        = r_count != 3'd0;
    w_full       = r_count == FIFO_FULL_COUNT;
    w_jam        = w_event[CH_NICKEL] && w_event[CH_DIME];
    w_single     = w_event[CH_NICKEL] ^ w_event[CH_DIME];
    w_push       = w_single && enable && (!w_full || w_pop);
    w_rejectNext = w_jam || (w_single && !w_push);
    w_pushCode   = w_event[CH_NICKEL] ? COIN_NICKEL : COIN_DIME;
  end

  // Queue storage needs no reset: occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= w_pushCode;
    end
  end

  // Queue pointers and occupancy; reset discards anything still queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: the popped code is shown for exactly one cycle and counted,
  // and rejects and jams are registered into one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coin      <= COIN_NONE;
      r_reject    <= 1'b0;
      r_jam       <= 1'b0;
      r_coinCount <= 8'd0;
    end else begin
      r_coin   <= w_pop ? r_fifo[r_rdPtr] : COIN_NONE;
      r_reject <= w_rejectNext;
      r_jam    <= w_jam;
      if (w_pop) begin
        r_coinCount <= r_coinCount + 8'd1;
      end
    end
  end

  assign coin       = r_coin;
  assign reject     = r_reject;
  assign jam        = r_jam;
  assign pending    = r_count;
  assign coin_count = r_coinCount;

endmodule
